tdm_demux_1x4: RTL and testbench
================================

Name: tdm_demux_1x4

Overview:
Receive-side counterpart of the team's 4:1 channel multiplexer. It takes a time-division-multiplexed serial sample stream, where one slot per cycle of valid data carries channels 0..3 in order. It reassembles each 4-slot frame into a parallel 4-channel word and presents it with a one-cycle valid pulse. It sits directly downstream of a TDM mux driven by a free-running 2-bit select, and rebuilds the original I[3:0]-style bus.

Parameters:
WIDTH, 1, bits per channel sample (1 reproduces the 4-bit I bus of the mux side)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  WIDTH  TDM sample for the current slot
din_valid  input  1  din carries a sample this cycle
frame_start  input  1  qualifies din as slot 0 of a new frame; ignored when din_valid=0
slot  output  2  slot index the next valid sample will fill (mirrors the mux-side S)
dout  output  4*WIDTH  reassembled frame; channel i at dout[i*WIDTH +: WIDTH]
dout_valid  output  1  one-cycle pulse, dout holds a new complete frame
sync_err  output  1  one-cycle pulse on framing violation
locked  output  1  framer aligned to frame boundaries

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: slot=0, dout=0, dout_valid=0, sync_err=0, locked=0, shadow registers=0.
- Unlocked (locked=0):
  - Valid samples without frame_start are dropped. No outputs change.
  - din_valid & frame_start: write shadow[0] <= din, set slot <= 1, locked <= 1.
- Locked, din_valid=1, frame_start=0:
  - slot 1 or 2: write shadow[slot] <= din, then slot increments.
  - slot 3: dout <= {din, shadow[2], shadow[1], shadow[0]}. dout_valid pulses the following cycle. slot wraps to 0.
  - slot 0: frame_start is missing. Drop the sample, pulse sync_err, set locked <= 0.
- Locked, din_valid & frame_start:
  - slot 0: normal frame start. shadow[0] <= din, slot <= 1.
  - slot 1..3: early frame_start. Discard the partial frame (no dout_valid) and pulse sync_err. The sample is taken as the new slot 0: shadow[0] <= din, slot <= 1, locked stays 1.
- din_valid=0: hold all state, including gaps mid-frame. Gaps of any length are tolerated.
- Latency: the slot-3 sample is registered on the clk edge where it is presented. dout and dout_valid are visible 1 cycle later.
- dout holds its value between pulses. Frames can arrive back-to-back, giving dout_valid every 4th cycle at full rate.
- dout_valid and sync_err never assert in the same cycle.
- rst mid-frame: the partial frame is lost, no dout_valid. Relock is required.

Optional Feature:
- Macro TDM_DEMUX_ERR_CNT_EN.
- When defined: adds output err_cnt[7:0]. It increments on each sync_err pulse, saturates at 255, and is cleared only by rst.
- When undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package tdm_pkg holds NUM_CH=4, SLOT_W=2, SLOT_FIRST=2'd0 and SLOT_LAST=2'd3. It is shared with the mux-side select generator.
- One sub-module, tdm_slot_ctr. It holds the slot counter and the locked flag, with inputs adv, restart and unlock.
- tdm_demux_1x4 holds the shadow registers, the output register and the error logic.

Test Plan:
- Basic frame (WIDTH=1, after rst): din=1,0,1,1 on 4 consecutive valid cycles, frame_start on the first -> 1 cycle after the last sample, dout=4'b1101, dout_valid=1 for 1 cycle, slot=0.
- Unlocked drop: 3 valid samples with no frame_start, then a full frame 0,1,1,0 starting with frame_start -> locked rises on the frame_start cycle; exactly one dout_valid, with dout=4'b0110.
- Gaps: one frame (din values 1,1,0,1) with din_valid=0 for 2 cycles between each slot -> one dout_valid, dout=4'b1011; slot holds during gaps.
- Early frame_start: frame_start at slot 2 -> sync_err pulse, no dout_valid. The next 3 samples complete a new frame, with that sample as channel 0.
- Missing frame_start: after a good frame, a valid sample with no frame_start -> sync_err=1, locked=0, sample dropped. err_cnt=1 when TDM_DEMUX_ERR_CNT_EN is defined.
- Reset mid-frame and back-to-back: rst after slot 2 -> no dout_valid, locked=0. Then 3 back-to-back frames -> dout_valid at cycles 4, 8 and 12 after the first sample.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM framing constants and types used by the mux-side select generator
// and the receive-side demultiplexer.
`timescale 1ns/1ps
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_FIRST = 2'd0;
    localparam slot_t SLOT_LAST  = 2'd3;

    // What the slot counter does with the current valid sample.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_ADV,
        ACT_RESTART,
        ACT_UNLOCK
    } act_e;

    function automatic slot_t slot_next(input slot_t s);
        return (s == SLOT_LAST) ? SLOT_FIRST : s + slot_t'(1);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter and lock flag for the TDM demultiplexer. restart takes the
// current sample as slot 0, unlock drops alignment, adv steps to the next slot.
`timescale 1ns/1ps
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              restart,
    input  logic              unlock,
    output logic [SLOT_W-1:0] slot,
    output logic              locked
);

    slot_t slot_nxt;
    logic  locked_nxt;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            slot   <= SLOT_FIRST;
            locked <= 1'b0;
        end else begin
            slot   <= slot_nxt;
            locked <= locked_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a
        // variable unassigned, which would infer a latch.
        slot_nxt   = slot;
        locked_nxt = locked;
        if (restart) begin
            slot_nxt   = slot_next(SLOT_FIRST);
            locked_nxt = 1'b1;
        end else if (unlock) begin
            slot_nxt   = SLOT_FIRST;
            locked_nxt = 1'b0;
        end else if (adv) begin
            slot_nxt   = slot_next(slot);
        end
    end

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: reassembles 4-slot frames into a parallel word.
// Optional macro TDM_DEMUX_ERR_CNT_EN adds a saturating sync error counter.
`timescale 1ns/1ps
module tdm_demux_1x4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        din,
    input  logic                    din_valid,
    input  logic                    frame_start,
    output logic [SLOT_W-1:0]       slot,
    output logic [NUM_CH*WIDTH-1:0] dout,
    output logic                    dout_valid,
    output logic                    sync_err,
    output logic                    locked
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt
`endif
);

    act_e act;
    logic err;
    logic frame_done;

    // Channels 0..NUM_CH-2 wait here until the last slot arrives.
    logic [NUM_CH-2:0][WIDTH-1:0] shadow;

    tdm_slot_ctr u_slot_ctr (
        .clk     (clk),
        .rst     (rst),
        .adv     (act == ACT_ADV),
        .restart (act == ACT_RESTART),
        .unlock  (act == ACT_UNLOCK),
        .slot    (slot),
        .locked  (locked)
    );

    always_comb begin
        act        = ACT_HOLD;
        err        = 1'b0;
        frame_done = 1'b0;
        if (din_valid) begin
            if (frame_start) begin
                // A frame_start while mid-frame abandons the partial frame.
                act = ACT_RESTART;
                err = locked && (slot != SLOT_FIRST);
            end else if (locked) begin
                if (slot == SLOT_FIRST) begin
                    act = ACT_UNLOCK;
                    err = 1'b1;
                end else begin
                    act        = ACT_ADV;
                    frame_done = (slot == SLOT_LAST);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the shadow array is reset too, so a frame completed right
        // after reset can never expose stale channel data.
        if (rst) begin
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= frame_done;
            sync_err   <= err;
            if (act == ACT_RESTART)
                shadow[0] <= din;
            for (int i = 1; i < NUM_CH - 1; i++) begin
                if (act == ACT_ADV && slot == slot_t'(i))
                    shadow[i] <= din;
            end
            if (frame_done)
                dout <= {din, shadow};
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= 8'd0;
        else if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed bench for tdm_demux_1x4 with a scoreboard of expected frames.
`timescale 1ns/1ps
module tb_tdm_demux_1x4;

    localparam int WIDTH = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_start;
    logic [1:0]         slot;
    logic [4*WIDTH-1:0] dout;
    logic               dout_valid;
    logic               sync_err;
    logic               locked;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0]         err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int se_cnt  = 0;
    logic [4*WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    tdm_demux_1x4 #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .slot        (slot),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .sync_err    (sync_err),
        .locked      (locked)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one slot, then return just after the edge that consumed it.
    task automatic drive(input logic v, input logic fs, input logic [WIDTH-1:0] d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Scoreboard side: every dout_valid pulse consumes one expected frame.
    always @(negedge clk) begin
        logic [4*WIDTH-1:0] e;
        if (dout_valid) begin
            dv_cnt++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("sb_dout", 32'(dout), 32'(e));
        end
        if (sync_err) se_cnt++;
        if (dout_valid || sync_err)
            check("dv_se_exclusive", 32'(dout_valid & sync_err), 32'd0);
    end

    initial begin
        logic [WIDTH-1:0]   fr[4];
        logic [WIDTH-1:0]   d;

        rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0; din = '0;
        do_reset();
        check("rst_slot",     32'(slot),       32'd0);
        check("rst_dout",     32'(dout),       32'd0);
        check("rst_dv",       32'(dout_valid), 32'd0);
        check("rst_se",       32'(sync_err),   32'd0);
        check("rst_locked",   32'(locked),     32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("rst_err_cnt",  32'(err_cnt),    32'd0);
`endif

        // Basic frame 1,0,1,1
        drive(1, 1, 1);
        check("basic_locked", 32'(locked), 32'd1);
        check("basic_slot1",  32'(slot),   32'd1);
        drive(1, 0, 0);
        drive(1, 0, 1);
        exp_q.push_back(4'b1101);
        drive(1, 0, 1);
        check("basic_dv",   32'(dout_valid), 32'd1);
        check("basic_dout", 32'(dout),       32'hD);
        check("basic_slot", 32'(slot),       32'd0);
        idle(1);
        check("basic_dv_pulse", 32'(dout_valid), 32'd0);
        check("basic_hold",     32'(dout),       32'hD);
        idle(1);
        check("basic_dv_cnt", 32'(dv_cnt), 32'd1);

        // Unlocked drop
        do_reset();
        check("drop_rst_dout", 32'(dout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1);
            check("drop_locked", 32'(locked),     32'd0);
            check("drop_slot",   32'(slot),       32'd0);
            check("drop_dv",     32'(dout_valid), 32'd0);
        end
        drive(1, 1, 0);
        check("drop_lock_rise", 32'(locked), 32'd1);
        drive(1, 0, 1);
        drive(1, 0, 1);
        exp_q.push_back(4'b0110);
        drive(1, 0, 0);
        check("drop_dv",   32'(dout_valid), 32'd1);
        check("drop_dout", 32'(dout),       32'h6);
        idle(2);
        check("drop_dv_cnt", 32'(dv_cnt), 32'd2);

        // Gaps of 2 idle cycles between slots, samples 1,1,0,1
        fr[0] = 1; fr[1] = 1; fr[2] = 0; fr[3] = 1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back(4'b1011);
            drive(1, k == 0, fr[k]);
            if (k < 3) begin
                for (int g = 0; g < 2; g++) begin
                    idle(1);
                    check("gap_slot", 32'(slot),       32'(k + 1));
                    check("gap_dv",   32'(dout_valid), 32'd0);
                end
            end
        end
        check("gap_dout", 32'(dout), 32'hB);
        idle(2);
        check("gap_dv_cnt", 32'(dv_cnt), 32'd3);

        // Early frame_start at slot 2
        drive(1, 1, 0);
        drive(1, 0, 1);
        check("early_slot2", 32'(slot), 32'd2);
        drive(1, 1, 1);
        check("early_se",     32'(sync_err),   32'd1);
        check("early_dv",     32'(dout_valid), 32'd0);
        check("early_slot",   32'(slot),       32'd1);
        check("early_locked", 32'(locked),     32'd1);
        drive(1, 0, 0);
        check("early_se_pulse", 32'(sync_err), 32'd0);
        drive(1, 0, 0);
        exp_q.push_back(4'b1001);
        drive(1, 0, 1);
        check("early_new_dv",   32'(dout_valid), 32'd1);
        check("early_new_dout", 32'(dout),       32'h9);
        idle(2);
        check("early_dv_cnt", 32'(dv_cnt), 32'd4);
        check("early_se_cnt", 32'(se_cnt), 32'd1);

        // Missing frame_start after a good frame
        do_reset();
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("miss_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        drive(1, 1, 1);
        drive(1, 0, 0);
        drive(1, 0, 0);
        exp_q.push_back(4'b0001);
        drive(1, 0, 0);
        idle(1);
        drive(1, 0, 1);
        check("miss_se",     32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked),   32'd0);
        check("miss_slot",   32'(slot),     32'd0);
        check("miss_dout",   32'(dout),     32'h1);
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("miss_err_cnt", 32'(err_cnt), 32'd1);
`endif
        drive(1, 0, 1);
        check("miss_se_pulse", 32'(sync_err), 32'd0);
        idle(2);
        check("miss_dv_cnt", 32'(dv_cnt), 32'd5);
        check("miss_se_cnt", 32'(se_cnt), 32'd2);

        // Reset mid-frame
        drive(1, 1, 1);
        drive(1, 0, 0);
        drive(1, 0, 1);
        check("rstmid_slot3", 32'(slot), 32'd3);
        rst = 1'b1;
        drive(1, 0, 1);
        rst = 1'b0;
        check("rstmid_dv",     32'(dout_valid), 32'd0);
        check("rstmid_locked", 32'(locked),     32'd0);
        check("rstmid_slot",   32'(slot),       32'd0);
        idle(1);
        check("rstmid_dv2", 32'(dout_valid), 32'd0);

        // Three back-to-back frames: dout_valid after samples 4, 8, 12
        for (int i = 0; i < 12; i++) begin
            d = WIDTH'($urandom);
            fr[i % 4] = d;
            if (i % 4 == 3) exp_q.push_back({fr[3], fr[2], fr[1], fr[0]});
            drive(1, i % 4 == 0, d);
            check("b2b_dv", 32'(dout_valid), 32'(i % 4 == 3));
            check("b2b_se", 32'(sync_err),   32'd0);
        end
        idle(2);
        check("final_dv_cnt",  32'(dv_cnt),        32'd8);
        check("final_se_cnt",  32'(se_cnt),        32'd2);
        check("final_drained", 32'(exp_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
